cam_init_seq: RTL

CAM_INIT_SEQ -- requirements
Module: cam_init_seq

---
 rtl/cam_init_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cam_init_seq.sv
// cam_init_seq: camera power-up sequencer (reset hold, wake wait, register table replay with delays).
// Define CAM_INIT_SEQ_RETRY_EN to re-issue a nacked write up to 3 times before failing.
module cam_init_seq #(
  parameter int unsigned RST_HOLD_CYC = 50000,
  parameter int unsigned WAKE_CYC     = 1000000,
  parameter int unsigned MS_CYC       = 50000,
  parameter int unsigned TBL_AW       = 8
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TBL_AW-1:0] err_idx,
  output logic              cam_rst,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_done,
  input  logic              wr_nack
);
  localparam int unsigned DLY_MAX = 255 * MS_CYC;
  localparam int unsigned HW_MAX  = RST_HOLD_CYC > WAKE_CYC ? RST_HOLD_CYC : WAKE_CYC;
  localparam int unsigned CNT_MAX = HW_MAX > DLY_MAX ? HW_MAX : DLY_MAX;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, RST_HOLD, WAKE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, DONE, ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          can_retry;
  logic          last;

  assign last = &tbl_addr;

`ifdef CAM_INIT_SEQ_RETRY_EN
  logic [1:0] rty;
  // counts re-issues of the current entry; cleared whenever a new entry is fetched
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) rty <= '0;
    else if (state != ISSUE && state != WAIT_DONE) rty <= '0;
    else if (state == WAIT_DONE && wr_done && wr_nack && rty != 2'd3) rty <= rty + 2'd1;
  assign can_retry = rty != 2'd3;
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge clk_50m or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cam_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      tbl_addr <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (start && (state == IDLE || state == DONE || state == ERROR)) begin
      state    <= RST_HOLD;
      cnt      <= '0;
      cam_rst  <= 1'b1;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      tbl_addr <= '0;
    end else
      case (state)
        RST_HOLD:
          if (cnt == CW'(RST_HOLD_CYC - 1)) begin
            cam_rst <= 1'b0;
            cnt     <= '0;
            state   <= WAKE;
          end else cnt <= cnt + CW'(1);
        WAKE:
          if (cnt == CW'(WAKE_CYC - 1)) begin
            cnt   <= '0;
            state <= FETCH;
          end else cnt <= cnt + CW'(1);
        FETCH: state <= DECODE;
        DECODE:
          if (tbl_data[23:8] == 16'hFFFF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tbl_data[23:8] == 16'hFFFE) begin
            // counts down; a zero-length delay still spends one cycle in DELAY
            cnt   <= CW'(tbl_data[7:0] * MS_CYC);
            state <= DELAY;
          end else begin
            wr_addr  <= tbl_data[23:8];
            wr_data  <= tbl_data[7:0];
            wr_valid <= 1'b1;
            state    <= ISSUE;
          end
        ISSUE:
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= WAIT_DONE;
          end
        WAIT_DONE:
          if (wr_done) begin
            if (wr_nack && can_retry) begin
              wr_valid <= 1'b1;
              state    <= ISSUE;
            end else if (wr_nack || last) begin
              state   <= ERROR;
              busy    <= 1'b0;
              err     <= 1'b1;
              err_idx <= tbl_addr;
            end else begin
              tbl_addr <= tbl_addr + TBL_AW'(1);
              state    <= FETCH;
            end
          end
        DELAY:
          if (cnt <= CW'(1)) begin
            cnt <= '0;
            if (last) begin
              state   <= ERROR;
              busy    <= 1'b0;
              err     <= 1'b1;
              err_idx <= tbl_addr;
            end else begin
              tbl_addr <= tbl_addr + TBL_AW'(1);
              state    <= FETCH;
            end
          end else cnt <= cnt - CW'(1);
        default: ;
      endcase
endmodule
